seg7_scan_controller: RTL and testbench
=======================================

Name: seg7_scan_controller

Overview:
Time-multiplexing controller for the board's 8-digit seven-segment display. It is driven by the processor top level. It accepts a 32-bit display word over a valid/ready handshake and shows it as 8 hex digits. It steps through the digits one at a time, with a blanking dead-time between digits to prevent ghosting, and swaps in new data only at frame boundaries so no frame is ever torn.

Parameters:
REFRESH_DIV, 100000, cycles each digit is driven per slot (must be >= 1)
DEAD_CYCLES, 1000, blanking cycles before each digit slot (must be >= 1)

Ports:
Clk  input  1  system clock; all logic on rising edge
Rst  input  1  synchronous, active-low reset
data_in  input  32  display word; nibble i maps to digit i (digit 0 = rightmost)
data_valid  input  1  data_in is valid this cycle
data_ready  output  1  controller can accept a word; transfer occurs when valid and ready are both high
blank_lz  input  1  when 1, suppress leading-zero digits
out7  output  7  segments {g,f,e,d,c,b,a}, active-low
en_out  output  8  digit enables, active-low; bit i drives digit i
frame_done  output  1  one-cycle pulse at the end of each 8-digit frame

Behaviour:
- Reset (Rst=0 at a rising edge, on any cycle, including mid-frame):
  - State goes to BLANK, digit index to 0, slot counter to 0.
  - Display register is cleared to 0; the pending word is discarded and pending is marked empty.
  - Outputs: data_ready=1, out7=7'h7F, en_out=8'hFF, frame_done=0.
- Registers: one pending register (a 1-deep buffer) and one display register.
- Handshake:
  - data_ready equals "pending empty".
  - When data_valid and data_ready are both 1, data_in is captured into pending, and data_ready goes to 0 on the next cycle.
  - data_in is ignored whenever data_ready=0.
- FSM, two states:
  - BLANK: en_out=8'hFF, out7=7'h7F. Lasts DEAD_CYCLES cycles, then goes to DRIVE.
  - DRIVE: drives digit[idx] for REFRESH_DIV cycles, then goes to BLANK with idx+1. idx wraps from 7 to 0.
  - The slot counter resets to 0 on every state change.
- Frame end, defined as the last DRIVE cycle of idx=7:
  - frame_done=1 for that single cycle.
  - If pending is full, the display register loads pending on that clock edge, pending becomes empty, and data_ready=1 on the following cycle.
- Simultaneous events at frame end:
  - A handshake on the frame-end cycle is only possible if pending was already empty. That word goes into pending and is shown in the following frame, not the current one.
  - A word already pending is never overwritten.
- Frame period is exactly 8*(DEAD_CYCLES+REFRESH_DIV) cycles. The first frame after reset starts with the BLANK of digit 0.
- DRIVE output decode (combinational from registered state, idx, display register, blank_lz):
  - en_out = ~(8'b1 << idx).
  - out7 = hex pattern of nibble[idx]: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex values).
- Leading-zero suppression:
  - If blank_lz=1, idx>=1, and nibbles idx..7 are all zero, the digit is suppressed: en_out=8'hFF and out7=7'h7F for that slot.
  - Slot timing is unchanged by suppression.
  - Digit 0 is never suppressed.
  - blank_lz is sampled live, not latched.
- frame_done is 0 in all cycles other than the frame-end cycle.

Test Plan:
All scenarios use REFRESH_DIV=4 and DEAD_CYCLES=2, giving a 48-cycle frame.
1. Reset: hold Rst=0 for 3 cycles -> out7=7F, en_out=FF, data_ready=1, frame_done=0. After release: 2 cycles with en_out=FF, then 4 cycles with en_out=FE and out7=40, then 2 blank cycles, then en_out=FD.
2. Load: data_in=0x12345678 with data_valid=1 in cycle 5 -> data_ready=0 from cycle 6; all digits show 40 until frame_done. Next frame: digit0 shows 00 (8) with en_out=FE; digit7 shows 79 (1) with en_out=7F; data_ready=1 the cycle after frame_done.
3. Back-pressure: load word A, then hold data_valid=1 with word B -> B is not captured while data_ready=0. B is captured the cycle after frame_done and displayed one frame after A.
4. Leading zeros: display 0x000000A5.
   - blank_lz=1 -> digit0 out7=12, digit1 out7=08, digits 2..7 en_out=FF.
   - blank_lz=0 -> digits 2..7 show 40.
   - display 0x00000000 with blank_lz=1 -> only digit0 lit, showing 40.
5. Mid-frame reset: display 0xFFFFFFFF with word pending; assert Rst=0 during the digit-3 DRIVE slot -> next cycle shows reset values. After release, digits show 40 and data_ready=1 (pending dropped).
6. Periodicity: free-run 5 frames -> frame_done pulses exactly every 48 cycles, each pulse 1 cycle wide. Each en_out bit goes low exactly once per frame, for 4 cycles.

Source files
------------

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed driver for an 8-digit active-low seven-segment display.
// A 1-deep pending buffer feeds the display register only at frame boundaries.
//
// state | meaning
// BLANK | all digits off for DEAD_CYCLES cycles (anti-ghosting dead-time)
// DRIVE | digit[idx] lit for REFRESH_DIV cycles
module seg7_scan_controller #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic        blank_lz,
  output logic [6:0]  out7,
  output logic [7:0]  en_out,
  output logic        frame_done
);

  localparam int CMAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

  state_t        state;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic [31:0]   pend;
  logic [31:0]   disp;
  logic          pend_full;

  logic          last_blank;
  logic          last_drive;
  logic          frame_end;
  logic [3:0]    nib;
  logic          lz_hide;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign last_blank = (state == BLANK) && (cnt == CW'(DEAD_CYCLES - 1));
  assign last_drive = (state == DRIVE) && (cnt == CW'(REFRESH_DIV - 1));
  assign frame_end  = last_drive && (idx == 3'd7);
  assign frame_done = frame_end;
  assign data_ready = ~pend_full;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= BLANK;
      idx       <= 3'd0;
      cnt       <= '0;
      disp      <= 32'd0;
      pend      <= 32'd0;
      pend_full <= 1'b0;
    end else begin
      case (state)
        BLANK: begin
          if (last_blank) begin
            state <= DRIVE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (last_drive) begin
            state <= BLANK;
            idx   <= idx + 3'd1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase

      // ready is low whenever pending is full, so swap and capture never collide
      if (frame_end && pend_full) begin
        disp      <= pend;
        pend_full <= 1'b0;
      end else if (data_valid && !pend_full) begin
        pend      <= data_in;
        pend_full <= 1'b1;
      end
    end
  end

  assign nib     = disp[{idx, 2'b00} +: 4];
  assign lz_hide = blank_lz && (idx != 3'd0) && ((disp >> {idx, 2'b00}) == 32'd0);

  always_comb begin
    out7   = 7'h7F;
    en_out = 8'hFF;
    if (state == DRIVE && !lz_hide) begin
      out7   = hex7(nib);
      en_out = ~(8'b1 << idx);
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Randomized scoreboard bench for seg7_scan_controller; expected outputs come
// from a frame-position model (cycle count modulo frame/slot lengths).
module tb_seg7_scan_controller;

  localparam int RD    = 4;
  localparam int DC    = 2;
  localparam int SLOT  = RD + DC;
  localparam int FRAME = 8 * SLOT;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic        data_valid = 1'b0;
  logic        blank_lz = 1'b0;
  logic        data_ready;
  logic [6:0]  out7;
  logic [7:0]  en_out;
  logic        frame_done;

  seg7_scan_controller #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
    .Clk(Clk), .Rst(Rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .blank_lz(blank_lz), .out7(out7),
    .en_out(en_out), .frame_done(frame_done)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [7:0] en;
    logic       rdy;
    logic       fd;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // model state: t counts cycles since the last reset edge
  bit          m_live = 0;
  int          t = 0;
  logic [31:0] m_disp = 32'd0;
  logic [31:0] m_pend = 32'd0;
  bit          m_full = 0;

  function automatic exp_t expect_now(input logic lz);
    exp_t e;
    int pos, slot, w, top;
    pos  = t % FRAME;
    slot = pos / SLOT;
    w    = pos % SLOT;
    e.rdy = !m_full;
    e.fd  = (pos == FRAME - 1);
    e.seg = 7'h7F;
    e.en  = 8'hFF;
    if (w >= DC) begin
      top = 0;
      for (int i = 0; i < 8; i++)
        if (m_disp[4*i +: 4] != 4'd0) top = i;
      if (!(lz && slot > top)) begin
        e.en[slot] = 1'b0;
        e.seg = seg_tab[m_disp[4*slot +: 4]];
      end
    end
    return e;
  endfunction

  task automatic step(input logic rst, input logic vld, input logic [31:0] d, input logic lz);
    @(posedge Clk);
    #1;
    Rst = rst; data_valid = vld; data_in = d; blank_lz = lz;
    if (m_live) sb_q.push_back(expect_now(lz));
    if (!rst) begin
      m_live = 1; t = 0; m_disp = 32'd0; m_full = 0;
    end else if (m_live) begin
      if ((t % FRAME) == FRAME - 1 && m_full) begin
        m_disp = m_pend; m_full = 0;
      end else if (!m_full && vld) begin
        m_pend = d; m_full = 1;
      end
      t++;
    end
  endtask

  task automatic run(input int n, input logic lz);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'd0, lz);
  endtask

  task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endtask

  always @(negedge Clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      cmp("out7", {1'b0, out7}, {1'b0, e.seg});
      cmp("en_out", en_out, e.en);
      cmp("data_ready", {7'd0, data_ready}, {7'd0, e.rdy});
      cmp("frame_done", {7'd0, frame_done}, {7'd0, e.fd});
    end
  end

  initial begin
    logic [31:0] r, mask;
    logic lz;
    // reset held for several cycles
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
    // load a word in cycle 5, then watch it appear in the next frame
    run(5, 1'b0);
    step(1'b1, 1'b1, 32'h12345678, 1'b0);
    run(2 * FRAME, 1'b0);
    // back-pressure: A accepted, B held until the frame swap frees pending
    step(1'b1, 1'b1, 32'hA1B2C3D4, 1'b0);
    for (int i = 0; i < FRAME + 10; i++) step(1'b1, 1'b1, 32'h0BADF00D, 1'b0);
    run(2 * FRAME, 1'b0);
    // leading-zero suppression, live blank_lz toggling
    step(1'b1, 1'b1, 32'h000000A5, 1'b1);
    run(2 * FRAME, 1'b1);
    run(FRAME, 1'b0);
    step(1'b1, 1'b1, 32'h00000000, 1'b1);
    run(2 * FRAME, 1'b1);
    // mid-frame reset during the digit-3 drive slot with a word pending
    step(1'b1, 1'b1, 32'hFFFFFFFF, 1'b0);
    run(2 * FRAME, 1'b0);
    step(1'b1, 1'b1, 32'h87654321, 1'b0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((t % FRAME) / SLOT == 3 && (t % SLOT) >= DC + 1) break;
      run(1, 1'b0);
    end
    step(1'b0, 1'b0, 32'd0, 1'b0);
    run(FRAME, 1'b0);
    // free-run several frames
    run(5 * FRAME, 1'b0);
    // randomized traffic
    lz = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 64 == 0) lz = 1'($urandom_range(0, 1));
      r    = $urandom;
      mask = 32'hFFFFFFFF >> (4 * $urandom_range(0, 7));
      step(($urandom_range(0, 399) != 0), ($urandom_range(0, 19) == 0), r & mask, lz);
    end
    run(2, 1'b0);
    @(posedge Clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
